dff_reg_arbiter: RTL
====================

Name: dff_reg_arbiter

Overview:
Round-robin write arbiter and sequencer for a shared WIDTH-bit enabled-D-flip-flop register. Up to N_REQ requesters each present a write word. The block grants one requester at a time, captures its data and drives the register enable for exactly one cycle. It also supports a synchronous clear and keeps a saturating count of completed writes.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, register data width
IDW, 2, width of requester index (must equal ceil(log2(N_REQ)))

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester write request, level, held until granted
wdata  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
clr  input  1  synchronous clear request for the shared register
gnt  output  N_REQ  one-hot grant, asserted only in GRANT state
reg_en  output  1  register enable, high only in WRITE state
q  output  WIDTH  shared register contents
busy  output  1  high when state != IDLE
wr_id  output  IDW  index of the most recently written requester
wr_count  output  16  completed-write counter, saturating

Behaviour:
- Reset (reset=0, asynchronous) forces the following, regardless of clk:
  - state=IDLE, q=0, hold=0, winner=0, ptr=0
  - gnt=0, reg_en=0, busy=0, wr_id=0, wr_count=0
- Reset mid-transaction aborts the transaction with no write.
- FSM states: IDLE, GRANT, WRITE, CLEAR.
- IDLE:
  - clr=1 -> CLEAR. clr has priority over req.
  - else if |req -> latch winner, go to GRANT.
  - else stay in IDLE.
- Winner selection: first set req bit searching upward from ptr, wrapping N_REQ-1 -> 0.
- GRANT:
  - If req[winner]=1: gnt[winner]=1 (combinational on state, winner and req[winner]); hold <= wdata slice[winner]; next state WRITE.
  - If req[winner]=0 (withdrawn): gnt=0, no capture, ptr unchanged, next state IDLE.
  - clr is ignored in GRANT; it is sampled again on return to IDLE.
- WRITE:
  - reg_en=1 for this cycle; q <= hold at the end of the cycle.
  - wr_id <= winner.
  - wr_count <= wr_count+1, saturating at 16'hFFFF.
  - ptr <= winner+1, wrapping to 0 after N_REQ-1.
  - Next state IDLE.
- CLEAR: q <= 0 for one cycle, then IDLE. clr does not touch wr_count, wr_id or ptr.
- Latency:
  - req sampled in IDLE at edge k.
  - gnt is high during cycle k+1.
  - q updates at edge k+2.
  - Minimum spacing between writes is 3 cycles.
- Requester protocol: deassert req in the cycle after gnt is seen. If req is still high on return to IDLE it is treated as a new request, but round-robin moves priority past that requester.
- Ports are synchronous to clk. wdata must be stable while req is high.
- q holds its value in every state except WRITE and CLEAR.

Test Plan:
- Reset then idle: assert reset=0 mid-cycle with req=4'b1111 -> all outputs 0 immediately. Release reset with req=0 -> busy=0 and q=0 indefinitely.
- Single write: req=4'b0100, slice2=8'hA5 -> gnt=4'b0100 for one cycle. Next cycle reg_en=1. Then q=8'hA5, wr_id=2, wr_count=1.
- Round-robin fairness: req=4'b1111 held continuously with slice i=8'h10+i -> grant order 0,1,2,3,0. q sequence 10,11,12,13,10 at 3-cycle spacing; wr_count=5.
- Clear priority: clr=1 and req=4'b0001 in the same IDLE cycle -> CLEAR first, q=0. Then grant 0 follows, q=slice0. wr_count increments only for the write.
- Withdrawn request: req=4'b0010 pulsed for one cycle only -> GRANT sees req[1]=0. gnt stays 0, no reg_en, q and ptr unchanged, back to IDLE.
- Reset mid-operation and saturation:
  - Pull reset=0 during WRITE -> q=0, no write, wr_count=0.
  - Force 65536 writes -> wr_count stays at 16'hFFFF.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
// Round-robin write arbiter/sequencer for one shared enabled-DFF register.
// Ports: clk, reset (async, low), req/wdata in, clr in; gnt, reg_en, q, busy, wr_id, wr_count out.
module dff_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [IDW-1:0]         wr_id,
  output logic [15:0]            wr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   wr_id_q, wr_id_d;
  logic [15:0]      wr_count_q, wr_count_d;

  logic [IDW-1:0]   pick;
  logic             pick_vld;
  logic             win_req;
  logic [WIDTH-1:0] win_data;
  logic [IDW-1:0]   ptr_inc;

  // Rotating search: first set req bit at or above ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = IDW'(j);
      end
    end
  end

  assign win_req  = req[winner_q];
  assign win_data = wdata[int'(winner_q)*WIDTH +: WIDTH];

  assign ptr_inc = (winner_q == IDW'(N_REQ-1)) ?
                   '0 : winner_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    hold_d     = hold_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    wr_id_d    = wr_id_q;
    wr_count_d = wr_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
        end else if (pick_vld) begin
          winner_d = pick;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn request drops back to IDLE untouched.
        if (win_req) begin
          hold_d  = win_data;
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        q_d     = hold_q;
        wr_id_d = winner_q;
        ptr_d   = ptr_inc;
        if (wr_count_q != 16'hFFFF)
          wr_count_d = wr_count_q + 16'd1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        q_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      hold_q     <= '0;
      winner_q   <= '0;
      ptr_q      <= '0;
      wr_id_q    <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      hold_q     <= hold_d;
      winner_q   <= winner_d;
      ptr_q      <= ptr_d;
      wr_id_q    <= wr_id_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Grant follows the live request so a withdrawal masks it at once.
  always_comb begin
    gnt = '0;
    if (state_q == S_GRANT && win_req)
      gnt[winner_q] = 1'b1;
  end

  assign reg_en   = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign q        = q_q;
  assign wr_id    = wr_id_q;
  assign wr_count = wr_count_q;

endmodule
